voice_matcher: RTL and testbench
================================

VOICE_MATCHER -- requirements
Module: voice_matcher

Interface
REQ-001 Parameter NUM_DIRS, 4: number of stored command templates; legal range 2..8.
REQ-002 Parameter CHUNKS, 2830: words recorded and compared per utterance.
REQ-003 Parameter ADDR_W, 12: RAM address width; 2**ADDR_W SHALL be >= CHUNKS.
REQ-004 Parameter SAMPLE_W, 8, and LANES, 4: word width is LANES*SAMPLE_W.
REQ-005 Parameter THRESH, 3: maximum per-lane absolute difference that counts as a match.
REQ-006 Parameter DEFAULT_DIR, 1: index reported on a tie or an empty score.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  reset; asynchronous, active-high.
REQ-009 start  in  1  one-cycle pulse that begins a record pass; ignored unless the block is in IDLE.
REQ-010 compare_en  in  1  sampled when recording ends; 1 = run the compare pass, 0 = return to IDLE.
REQ-011 abort  in  1  returns to IDLE on the next edge from any state; tallies are cleared.
REQ-012 smp_valid  in  1  a sampler word is ready.
REQ-013 smp_data  in  LANES*SAMPLE_W  the sampler word.
REQ-014 smp_en  out  1  enables the sampler.
REQ-015 ram_wr  out  1  write strobe to the capture RAM.
REQ-016 ram_addr  out  ADDR_W  shared address to the capture and template RAMs.
REQ-017 ram_wdata  out  LANES*SAMPLE_W  write data to the capture RAM.
REQ-018 ram_rdata  in  LANES*SAMPLE_W  capture RAM read data.
REQ-019 tmpl_rdata  in  NUM_DIRS x LANES*SAMPLE_W  template read data; both RAMs have a 1-cycle read latency.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 match  out  $clog2(NUM_DIRS)  winning direction index.
REQ-022 match_valid  out  1  one-cycle pulse when match updates.
REQ-023 match_tie  out  1  high when the last result fell back to DEFAULT_DIR; held with match.

Function
REQ-024 States: IDLE, RECORD, COMPARE, DRAIN, DECIDE.
REQ-025 IDLE: on start, clear the address counter and tallies, then go to RECORD.
REQ-026 RECORD:
- smp_en = 1 while addr < CHUNKS.
- On smp_valid: ram_wr = 1, ram_wdata = smp_data, addr increments.
- At addr == CHUNKS: smp_en = 0, addr clears; go to COMPARE if compare_en = 1, else IDLE.
REQ-027 COMPARE: issue one address per cycle, 0..CHUNKS-1; a read-valid flag is delayed by one cycle to align with read data; go to DRAIN after the last address is issued.
REQ-028 DRAIN: one cycle to accumulate the final word; then DECIDE.
REQ-029 Scoring: per template and per aligned word, the score is the number of lanes with |ram_rdata lane - template lane| <= THRESH, computed as unsigned with SAMPLE_W+1 bits; the score is added to that direction's tally.
REQ-030 Tally width is $clog2(CHUNKS*LANES+1); tallies SHALL NOT wrap.
REQ-031 DECIDE:
- match = the strictly unique maximum tally.
- If the maximum is shared, or every tally is 0: match = DEFAULT_DIR and match_tie = 1.
- Pulse match_valid; go to IDLE.
REQ-032 Latency: match_valid asserts exactly CHUNKS+2 cycles after COMPARE is entered.
REQ-033 start while busy is ignored; abort has priority over every other transition.
REQ-034 smp_valid outside RECORD is ignored; no ram_wr is generated.

Reset
REQ-035 On rst: IDLE; addr = 0; tallies = 0; match = DEFAULT_DIR; match_tie = 0; match_valid, ram_wr, smp_en, busy = 0.

Structure
REQ-036 The state enum and the default parameter values are defined in the shared voice_pkg package.
REQ-037 Sub-module word_scorer: combinational LANES-lane threshold count; instantiated once per direction with a generate loop.

Verification
REQ-038 Identical capture and template 0, all other templates far off -> match = 0, match_tie = 0, tally0 = CHUNKS*LANES.
REQ-039 Templates 2 and 3 equal to the capture -> match = 1, match_tie = 1.
REQ-040 Lane difference of exactly THRESH counts; THRESH+1 does not; checked at sample values 0 and 255.
REQ-041 abort in mid-COMPARE -> IDLE next cycle, no match_valid; a following run produces a clean result.
REQ-042 compare_en = 0 -> exactly CHUNKS ram_wr pulses, return to IDLE, match unchanged.
REQ-043 rst asserted in RECORD -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/voice_pkg.sv
// Shared definitions for the voice command matcher: controller states and
// default parameter values.
package voice_pkg;

    localparam int unsigned DEF_NUM_DIRS    = 4;
    localparam int unsigned DEF_CHUNKS      = 2830;
    localparam int unsigned DEF_ADDR_W      = 12;
    localparam int unsigned DEF_SAMPLE_W    = 8;
    localparam int unsigned DEF_LANES       = 4;
    localparam int unsigned DEF_THRESH      = 3;
    localparam int unsigned DEF_DEFAULT_DIR = 1;

    typedef enum logic [2:0] {
        IDLE,
        RECORD,
        COMPARE,
        DRAIN,
        DECIDE
    } state_t;

endpackage

// File: rtl/word_scorer.sv
// Counts the lanes of one word whose absolute difference from the matching
// template lane is within THRESH.
module word_scorer
    import voice_pkg::*;
#(
    parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
    parameter int unsigned LANES    = DEF_LANES,
    parameter int unsigned THRESH   = DEF_THRESH
) (
    input  logic [LANES*SAMPLE_W-1:0]    cap_word,
    input  logic [LANES*SAMPLE_W-1:0]    tmpl_word,
    output logic [$clog2(LANES+1)-1:0]   score
);

    localparam int unsigned DIFF_W  = SAMPLE_W + 1;
    localparam int unsigned SCORE_W = $clog2(LANES + 1);

    logic [DIFF_W-1:0] lane_a;
    logic [DIFF_W-1:0] lane_b;
    logic [DIFF_W-1:0] lane_diff;

    // One extra bit keeps the subtraction from aliasing near 0 and full scale.
    always_comb begin
        score     = '0;
        lane_a    = '0;
        lane_b    = '0;
        lane_diff = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            lane_a    = {1'b0, cap_word[l*SAMPLE_W +: SAMPLE_W]};
            lane_b    = {1'b0, tmpl_word[l*SAMPLE_W +: SAMPLE_W]};
            lane_diff = (lane_a >= lane_b) ? (lane_a - lane_b) : (lane_b - lane_a);
            if (lane_diff <= DIFF_W'(THRESH)) begin
                score = score + SCORE_W'(1);
            end
        end
    end

endmodule

// File: rtl/voice_matcher.sv
// Records one utterance into the capture RAM, scores it word by word against
// every stored template and reports the direction with the unique best tally.
module voice_matcher
    import voice_pkg::*;
#(
    parameter int unsigned NUM_DIRS    = DEF_NUM_DIRS,
    parameter int unsigned CHUNKS      = DEF_CHUNKS,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned SAMPLE_W    = DEF_SAMPLE_W,
    parameter int unsigned LANES       = DEF_LANES,
    parameter int unsigned THRESH      = DEF_THRESH,
    parameter int unsigned DEFAULT_DIR = DEF_DEFAULT_DIR
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               compare_en,
    input  logic                               abort,
    input  logic                               smp_valid,
    input  logic [LANES*SAMPLE_W-1:0]          smp_data,
    output logic                               smp_en,
    output logic                               ram_wr,
    output logic [ADDR_W-1:0]                  ram_addr,
    output logic [LANES*SAMPLE_W-1:0]          ram_wdata,
    input  logic [LANES*SAMPLE_W-1:0]          ram_rdata,
    input  logic [NUM_DIRS*LANES*SAMPLE_W-1:0] tmpl_rdata,
    output logic                               busy,
    output logic [$clog2(NUM_DIRS)-1:0]        match,
    output logic                               match_valid,
    output logic                               match_tie
);

    localparam int unsigned WORD_W  = LANES * SAMPLE_W;
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned TALLY_W = $clog2(CHUNKS * LANES + 1);
    localparam int unsigned SCORE_W = $clog2(LANES + 1);
    localparam int unsigned MATCH_W = $clog2(NUM_DIRS);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    addr, addr_nxt;
    logic [ADDR_W-1:0]   ram_addr_nxt;
    logic                ram_wr_nxt;
    logic [WORD_W-1:0]   ram_wdata_nxt;
    logic                smp_en_nxt;
    logic                busy_nxt;
    logic                rd_valid, rd_valid_nxt;
    logic [MATCH_W-1:0]  match_nxt;
    logic                match_tie_nxt;
    logic                match_valid_nxt;
    logic [TALLY_W-1:0]  tally     [NUM_DIRS];
    logic [TALLY_W-1:0]  tally_nxt [NUM_DIRS];
    logic [SCORE_W-1:0]  score     [NUM_DIRS];
    logic [MATCH_W-1:0]  best_idx;
    logic [TALLY_W-1:0]  best_val;
    logic                shared;

    for (genvar g = 0; g < int'(NUM_DIRS); g++) begin : g_score
        word_scorer #(
            .SAMPLE_W (SAMPLE_W),
            .LANES    (LANES),
            .THRESH   (THRESH)
        ) u_scorer (
            .cap_word  (ram_rdata),
            .tmpl_word (tmpl_rdata[g*WORD_W +: WORD_W]),
            .score     (score[g])
        );
    end

    // Highest tally and whether any other direction reaches the same value.
    always_comb begin
        best_idx = '0;
        best_val = tally[0];
        shared   = 1'b0;
        for (int d = 1; d < int'(NUM_DIRS); d++) begin
            if (tally[d] > best_val) begin
                best_idx = MATCH_W'(d);
                best_val = tally[d];
                shared   = 1'b0;
            end else if (tally[d] == best_val) begin
                shared = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        addr_nxt        = addr;
        ram_addr_nxt    = ram_addr;
        ram_wr_nxt      = 1'b0;
        ram_wdata_nxt   = ram_wdata;
        rd_valid_nxt    = 1'b0;
        match_nxt       = match;
        match_tie_nxt   = match_tie;
        match_valid_nxt = 1'b0;
        tally_nxt       = tally;

        // Read data lags the issued address by one cycle.
        if (rd_valid) begin
            for (int d = 0; d < int'(NUM_DIRS); d++) begin
                tally_nxt[d] = tally[d] + TALLY_W'(score[d]);
            end
        end

        case (state)
            IDLE: begin
                if (start) begin
                    addr_nxt  = '0;
                    state_nxt = RECORD;
                    for (int d = 0; d < int'(NUM_DIRS); d++) tally_nxt[d] = '0;
                end
            end
            RECORD: begin
                if (addr == CNT_W'(CHUNKS)) begin
                    addr_nxt  = '0;
                    state_nxt = compare_en ? COMPARE : IDLE;
                end else if (smp_valid) begin
                    ram_wr_nxt    = 1'b1;
                    ram_wdata_nxt = smp_data;
                    ram_addr_nxt  = addr[ADDR_W-1:0];
                    addr_nxt      = addr + CNT_W'(1);
                end
            end
            COMPARE: begin
                rd_valid_nxt = 1'b1;
                addr_nxt     = addr + CNT_W'(1);
                if (addr == CNT_W'(CHUNKS - 1)) begin
                    addr_nxt  = '0;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = DECIDE;
            end
            DECIDE: begin
                match_valid_nxt = 1'b1;
                if (shared || (best_val == '0)) begin
                    match_nxt     = MATCH_W'(DEFAULT_DIR);
                    match_tie_nxt = 1'b1;
                end else begin
                    match_nxt     = best_idx;
                    match_tie_nxt = 1'b0;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (abort) begin
            state_nxt       = IDLE;
            addr_nxt        = '0;
            ram_wr_nxt      = 1'b0;
            rd_valid_nxt    = 1'b0;
            match_nxt       = match;
            match_tie_nxt   = match_tie;
            match_valid_nxt = 1'b0;
            for (int d = 0; d < int'(NUM_DIRS); d++) tally_nxt[d] = '0;
        end

        // Outside a write, the RAM address simply follows the counter.
        if (!ram_wr_nxt) begin
            ram_addr_nxt = addr_nxt[ADDR_W-1:0];
        end
        smp_en_nxt = (state_nxt == RECORD) && (addr_nxt < CNT_W'(CHUNKS));
        busy_nxt   = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr        <= '0;
            ram_addr    <= '0;
            ram_wr      <= 1'b0;
            ram_wdata   <= '0;
            smp_en      <= 1'b0;
            busy        <= 1'b0;
            rd_valid    <= 1'b0;
            match       <= MATCH_W'(DEFAULT_DIR);
            match_tie   <= 1'b0;
            match_valid <= 1'b0;
            for (int d = 0; d < int'(NUM_DIRS); d++) tally[d] <= '0;
        end else begin
            addr        <= addr_nxt;
            ram_addr    <= ram_addr_nxt;
            ram_wr      <= ram_wr_nxt;
            ram_wdata   <= ram_wdata_nxt;
            smp_en      <= smp_en_nxt;
            busy        <= busy_nxt;
            rd_valid    <= rd_valid_nxt;
            match       <= match_nxt;
            match_tie   <= match_tie_nxt;
            match_valid <= match_valid_nxt;
            for (int d = 0; d < int'(NUM_DIRS); d++) tally[d] <= tally_nxt[d];
        end
    end

endmodule

// File: tb/tb_voice_matcher.sv
// Directed bench for voice_matcher: table of capture/template patterns with
// hand-computed winners, plus abort, record-only, busy-start and reset cases.
module tb_voice_matcher;

    localparam int C  = 20;
    localparam int AW = 5;
    localparam int W  = 32;
    localparam int ND = 4;

    typedef struct packed {
        logic [7:0]              cap_base;
        logic                    spread;
        logic signed [3:0][9:0]  off;
        logic [3:0][3:0]         mask;
        logic [1:0]              exp_match;
        logic                    exp_tie;
    } vec_t;

    logic              clk, rst, start, compare_en, abort, smp_valid;
    logic [W-1:0]      smp_data;
    logic              smp_en, ram_wr, busy, match_valid, match_tie;
    logic [AW-1:0]     ram_addr;
    logic [W-1:0]      ram_wdata, ram_rdata;
    logic [ND*W-1:0]   tmpl_rdata;
    logic [1:0]        match;

    logic [W-1:0]      cap_mem  [32];
    logic [W-1:0]      cap_src  [32];
    logic [W-1:0]      tmpl_mem [ND][32];

    int errors = 0;
    int checks = 0;

    voice_matcher #(.CHUNKS(C), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .compare_en  (compare_en),
        .abort       (abort),
        .smp_valid   (smp_valid),
        .smp_data    (smp_data),
        .smp_en      (smp_en),
        .ram_wr      (ram_wr),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .tmpl_rdata  (tmpl_rdata),
        .busy        (busy),
        .match       (match),
        .match_valid (match_valid),
        .match_tie   (match_tie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture and template RAMs, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_wr) cap_mem[ram_addr] <= ram_wdata;
        ram_rdata <= cap_mem[ram_addr];
        for (int d = 0; d < ND; d++) tmpl_rdata[d*W +: W] <= tmpl_mem[d][ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int base, input int spread,
                                input int o0, input int o1, input int o2, input int o3,
                                input logic [3:0] m0, input logic [3:0] m1,
                                input logic [3:0] m2, input logic [3:0] m3,
                                input int em, input int et);
        vec_t v;
        v.cap_base  = 8'(base);
        v.spread    = 1'(spread);
        v.off[0]    = 10'(o0);
        v.off[1]    = 10'(o1);
        v.off[2]    = 10'(o2);
        v.off[3]    = 10'(o3);
        v.mask[0]   = m0;
        v.mask[1]   = m1;
        v.mask[2]   = m2;
        v.mask[3]   = m3;
        v.exp_match = 2'(em);
        v.exp_tie   = 1'(et);
        return v;
    endfunction

    // Template lane = capture lane + offset on masked lanes, else identical.
    task automatic load_vec(input vec_t v);
        for (int k = 0; k < C; k++) begin
            for (int l = 0; l < 4; l++) begin
                int c;
                int t;
                c = int'(v.cap_base) + (v.spread ? ((k * 3 + l) % 8) : 0);
                cap_src[k][l*8 +: 8] = 8'(c);
                for (int d = 0; d < ND; d++) begin
                    t = v.mask[d][l] ? c + int'($signed(v.off[d])) : c;
                    tmpl_mem[d][k][l*8 +: 8] = 8'(t);
                end
            end
        end
    endtask

    // One start..finish pass; 'since' counts negedges after the last capture write.
    task automatic do_run(input logic cen, input int abort_at, input int poke_at,
                          input logic junk, output int wr_cnt, output int end_since,
                          output logic seen_valid);
        int   k;
        int   cyc;
        int   since;
        logic done;
        k = 0; cyc = 0; since = -1; done = 1'b0;
        wr_cnt = 0; end_since = -1; seen_valid = 1'b0;
        @(negedge clk); start = 1'b1; compare_en = cen;
        @(negedge clk); start = 1'b0;
        while (!done && cyc < 6 * C + 40) begin
            if (smp_en && (cyc % 3 != 2) && k < C) begin
                smp_valid = 1'b1; smp_data = cap_src[k]; k++;
            end else if (!smp_en && junk) begin
                smp_valid = 1'b1; smp_data = 32'hDEAD_BEEF;
            end else begin
                smp_valid = 1'b0;
            end
            abort = (since >= 0) && (since == abort_at);
            start = (since >= 0) && (since == poke_at);
            @(negedge clk);
            cyc++;
            if (ram_wr) begin
                wr_cnt++;
                if (wr_cnt == C) since = 0;
            end else if (since >= 0) begin
                since++;
            end
            if (match_valid) begin
                seen_valid = 1'b1; end_since = since; done = 1'b1;
            end else if (!busy) begin
                end_since = since; done = 1'b1;
            end
        end
        smp_valid = 1'b0; abort = 1'b0; start = 1'b0;
        check("run_terminates", 32'(done), 32'd1);
    endtask

    vec_t vecs [11];
    int   wr_cnt, end_since, pulses;
    logic seen;

    initial begin
        rst = 1'b1; start = 1'b0; compare_en = 1'b0; abort = 1'b0;
        smp_valid = 1'b0; smp_data = '0;

        vecs[0]  = mk(100, 1,  0, 100, 100, 100, 4'hF, 4'hF, 4'hF, 4'hF, 0, 0);
        vecs[1]  = mk(100, 1, 50,  50,   0,   0, 4'hF, 4'hF, 4'hF, 4'hF, 1, 1);
        vecs[2]  = mk(100, 1, 10,  -3,   4,  -4, 4'hF, 4'hF, 4'hF, 4'hF, 1, 0);
        vecs[3]  = mk(100, 1, -4,   4,   3,  20, 4'hF, 4'hF, 4'hF, 4'hF, 2, 0);
        vecs[4]  = mk(100, 1, 20, -20,  30, -30, 4'hF, 4'hF, 4'hF, 4'hF, 1, 1);
        vecs[5]  = mk(100, 1,  3,  -3,  30,  30, 4'hF, 4'hF, 4'hF, 4'hF, 1, 1);
        vecs[6]  = mk(100, 1, 10,  10,  10,  10, 4'h1, 4'h3, 4'hF, 4'h7, 0, 0);
        vecs[7]  = mk(100, 1,  9,   9,   9,   9, 4'hF, 4'h1, 4'h0, 4'h3, 2, 0);
        vecs[8]  = mk(  0, 0,  4,   4,   3, 255, 4'hF, 4'hF, 4'hF, 4'hF, 2, 0);
        vecs[9]  = mk(255, 0, -4,  -4,  -4,  -3, 4'hF, 4'hF, 4'hF, 4'hF, 3, 0);
        vecs[10] = mk(100, 1,  5,   5,   5,   5, 4'h3, 4'h3, 4'hF, 4'hF, 1, 1);

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_match", 32'(match), 32'd1);
        check("rst_tie",   32'(match_tie), 32'd0);
        check("rst_valid", 32'(match_valid), 32'd0);
        check("rst_smp_en", 32'(smp_en), 32'd0);
        check("rst_ram_wr", 32'(ram_wr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Table-driven full passes
        for (int i = 0; i < 11; i++) begin
            load_vec(vecs[i]);
            do_run(1'b1, -1, -1, 1'b0, wr_cnt, end_since, seen);
            check($sformatf("v%0d_valid", i),   32'(seen), 32'd1);
            check($sformatf("v%0d_match", i),   32'(match), 32'(vecs[i].exp_match));
            check($sformatf("v%0d_tie", i),     32'(match_tie), 32'(vecs[i].exp_tie));
            check($sformatf("v%0d_latency", i), 32'(end_since), 32'(C + 3));
            check($sformatf("v%0d_wr_cnt", i),  32'(wr_cnt), 32'(C));
            @(negedge clk);
            check($sformatf("v%0d_pulse", i),   32'(match_valid), 32'd0);
        end

        // start while busy and stray smp_valid outside RECORD are ignored
        load_vec(vecs[3]);
        do_run(1'b1, -1, 5, 1'b1, wr_cnt, end_since, seen);
        check("poke_valid",   32'(seen), 32'd1);
        check("poke_match",   32'(match), 32'd2);
        check("poke_tie",     32'(match_tie), 32'd0);
        check("poke_latency", 32'(end_since), 32'(C + 3));
        check("poke_wr_cnt",  32'(wr_cnt), 32'(C));
        @(negedge clk);
        check("poke_idle", 32'(busy), 32'd0);

        // abort in the middle of COMPARE
        load_vec(vecs[0]);
        do_run(1'b1, 10, -1, 1'b0, wr_cnt, end_since, seen);
        check("abort_no_valid", 32'(seen), 32'd0);
        check("abort_to_idle",  32'(end_since), 32'd11);
        pulses = 0;
        for (int n = 0; n < C + 5; n++) begin
            @(negedge clk);
            if (match_valid) pulses++;
        end
        check("abort_no_late_valid", 32'(pulses), 32'd0);
        check("abort_match_held",    32'(match), 32'd2);
        do_run(1'b1, -1, -1, 1'b0, wr_cnt, end_since, seen);
        check("after_abort_valid", 32'(seen), 32'd1);
        check("after_abort_match", 32'(match), 32'd0);
        check("after_abort_tie",   32'(match_tie), 32'd0);

        // record only
        load_vec(vecs[9]);
        do_run(1'b0, -1, -1, 1'b0, wr_cnt, end_since, seen);
        check("rec_only_wr_cnt",  32'(wr_cnt), 32'(C));
        check("rec_only_to_idle", 32'(end_since), 32'd1);
        check("rec_only_no_valid", 32'(seen), 32'd0);
        check("rec_only_match",   32'(match), 32'd0);
        check("rec_only_tie",     32'(match_tie), 32'd0);
        pulses = 0;
        smp_valid = 1'b1; smp_data = 32'h0102_0304;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (ram_wr) pulses++;
        end
        smp_valid = 1'b0;
        check("idle_smp_no_wr", 32'(pulses), 32'd0);

        do_run(1'b1, -1, -1, 1'b0, wr_cnt, end_since, seen);
        check("pre_rst_match", 32'(match), 32'd3);

        // asynchronous reset while recording
        @(negedge clk); start = 1'b1; compare_en = 1'b1;
        @(negedge clk); start = 1'b0;
        smp_valid = 1'b1; smp_data = 32'h1122_3344;
        for (int n = 0; n < 10 && !ram_wr; n++) @(negedge clk);
        check("rr_wr_before", 32'(ram_wr), 32'd1);
        check("rr_busy_before", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rr_busy",     32'(busy), 32'd0);
        check("rr_smp_en",   32'(smp_en), 32'd0);
        check("rr_ram_wr",   32'(ram_wr), 32'd0);
        check("rr_ram_addr", 32'(ram_addr), 32'd0);
        check("rr_valid",    32'(match_valid), 32'd0);
        check("rr_match",    32'(match), 32'd1);
        check("rr_tie",      32'(match_tie), 32'd0);
        smp_valid = 1'b0;
        @(negedge clk); rst = 1'b0;

        load_vec(vecs[5]);
        do_run(1'b1, -1, -1, 1'b0, wr_cnt, end_since, seen);
        check("post_rst_valid", 32'(seen), 32'd1);
        check("post_rst_match", 32'(match), 32'd1);
        check("post_rst_tie",   32'(match_tie), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
